xor_stream_descrambler: RTL



---
 rtl/xor_stream_descrambler_pkg.sv | 17 +
 rtl/xor_stream_descrambler_lfsr_step.sv | 19 +
 rtl/xor_stream_descrambler_xor.sv | 17 +
 rtl/xor_stream_descrambler.sv | 134 +++++++++++++
 4 files changed

// File: rtl/xor_stream_descrambler_pkg.sv
// Shared constants and types for the XOR stream descrambler and its LFSR helper.
// No logic, no latency.
// Not applicable (package only).
package xor_descr_pkg;

    // Feedback taps of x^32+x^22+x^2+x+1: bits 31, 21, 1 and 0.
    localparam logic [31:0] LFSR_TAPS      = 32'h8020_0003;
    localparam logic [31:0] SEED_DEFAULT_C = 32'h0000_0001;
    // An all-zero LFSR state never leaves zero, so a zero seed is replaced by this.
    localparam logic [31:0] ZERO_SEED_SUB  = 32'h0000_0001;

    typedef enum logic {
        RUN    = 1'b0,
        RESEED = 1'b1
    } descr_state_e;

endpackage

// File: rtl/xor_stream_descrambler_lfsr_step.sv
// Keystream LFSR next-state function plus zero-seed substitution; shared with the transmitter.
// Purely combinational, zero latency.
// No handshake; the caller decides when to apply the results.
module xor_lfsr_step
    import xor_descr_pkg::*;
(
    input  logic [31:0] state_i,
    input  logic [31:0] seed_i,
    output logic [31:0] next_o,
    output logic [31:0] seed_fix_o
);

    // Fibonacci shift: feedback is the parity of the tapped bits, shifted in at bit 0.
    always_comb begin
        next_o     = {state_i[30:0], ^(state_i & LFSR_TAPS)};
        seed_fix_o = (seed_i == 32'h0) ? ZERO_SEED_SUB : seed_i;
    end

endmodule

// File: rtl/xor_stream_descrambler_xor.sv
// Generic word-wide XOR block used by the datapath.
// Purely combinational, zero latency.
// No handshake.
module xor_word #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);

    // Bitwise combine of the two operands.
    always_comb begin
        y_o = a_i ^ b_i;
    end

endmodule

// File: rtl/xor_stream_descrambler.sv
// Descrambles a valid/ready word stream by XOR with a locally regenerated LFSR keystream.
// One cycle from accept to out_valid; full throughput. Optional parity check via DESCR_PARITY_EN.
// in_ready drops while the output is held un-taken, during a seed_load cycle, and in RESEED.
module xor_stream_descrambler
    import xor_descr_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] SEED_DEFAULT = SEED_DEFAULT_C
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [15:0]      word_count
`ifdef DESCR_PARITY_EN
    ,
    input  logic             in_parity,
    output logic             parity_err
`endif
);

    descr_state_e     state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [15:0]      word_count_q, word_count_d;

    logic [WIDTH-1:0] lfsr_next;
    logic [WIDTH-1:0] seed_fix;
    logic [WIDTH-1:0] plain;
    logic             accept;

    xor_lfsr_step u_lfsr_step (
        .state_i    (lfsr_q),
        .seed_i     (seed_in),
        .next_o     (lfsr_next),
        .seed_fix_o (seed_fix)
    );

    // The keystream for a word is the LFSR state before it advances.
    xor_word #(.WIDTH(WIDTH)) u_xor (
        .a_i (in_data),
        .b_i (lfsr_q),
        .y_o (plain)
    );

    // Ready depends only on state, the output slot and seed_load, never on in_valid.
    always_comb begin
        in_ready = (state_q == RUN) && (!out_valid_q || out_ready) && !seed_load;
        accept   = in_valid && in_ready;
    end

    // Next-state and datapath updates; seed_load takes priority over any word.
    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        word_count_d = word_count_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;

        case (state_q)
            RUN: begin
                // A word still waiting for the consumer must drain before new keystream is used.
                if (seed_load && out_valid_q && !out_ready) begin
                    state_d = RESEED;
                end
            end
            RESEED: begin
                if (!out_valid_q || out_ready) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase

        if (seed_load) begin
            lfsr_d       = seed_fix;
            word_count_d = 16'h0;
        end else if (accept) begin
            lfsr_d       = lfsr_next;
            word_count_d = word_count_q + 16'd1;
        end

        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = plain;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State, keystream, counter and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            lfsr_q       <= SEED_DEFAULT;
            word_count_q <= 16'h0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            word_count_q <= word_count_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
        end
    end

`ifdef DESCR_PARITY_EN
    logic parity_err_q;

    // Parity flag is captured with the word and only meaningful while out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err_q <= 1'b0;
        end else if (accept) begin
            parity_err_q <= (^plain) ^ in_parity;
        end
    end

    assign parity_err = parity_err_q;
`endif

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign word_count = word_count_q;

endmodule
